// File: rtl/a_conditioner.sv
// a_conditioner: synchronises the raw asynchronous `a` input, debounces it
// with a four-state check machine and drives the clean level consumed by the
// downstream FSM block. It also produces one-cycle edge pulses and a
// saturating count of aborted checks for diagnostics.
module a_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_raw,
  input  logic             clr_cnt,
  output logic             a,
  output logic             a_rise,
  output logic             a_fall,
  output logic             busy,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-2:0] sync;
  logic                   s;
  logic                   abort;

  // The state register itself is the final synchroniser flop: the FSM acts on
  // the value leaving stage SYNC_STAGES-1, so a level sampled at E0 moves the
  // state at E(SYNC_STAGES-1).
  assign s = sync[SYNC_STAGES-2];

  // A check is aborted when the synchronised level reverts before acceptance.
  assign abort = ((state == CHK_HI) && !s) || ((state == CHK_LO) && s);

  // Synchroniser shift chain, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync[0] <= a_raw;
      for (int unsigned i = 1; i < SYNC_STAGES - 1; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // Debounce FSM with registered level, pulse and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOW;
      cnt    <= '0;
      a      <= 1'b0;
      a_rise <= 1'b0;
      a_fall <= 1'b0;
      busy   <= 1'b0;
    end else begin
      a_rise <= 1'b0;
      a_fall <= 1'b0;
      case (state)
        LOW: begin
          if (s) begin
            state <= CHK_HI;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
        end
        CHK_HI: begin
          if (!s) begin
            state <= LOW;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= HIGH;
            a      <= 1'b1;
            a_rise <= 1'b1;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            state <= CHK_LO;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
        end
        CHK_LO: begin
          if (s) begin
            state <= HIGH;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= LOW;
            a      <= 1'b0;
            a_fall <= 1'b1;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= LOW;
          a     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating glitch counter; clear wins over a simultaneous abort.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_a_conditioner.sv
// tb_a_conditioner: directed vectors with hand-computed expectations for the
// a_conditioner debouncer (defaults, except a 2-bit glitch counter).
module tb_a_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_raw = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       a;
  logic       a_rise;
  logic       a_fall;
  logic       busy;
  logic [1:0] glitch_cnt;

  int total = 0;
  int bad = 0;
  int rise_n = 0;
  int fall_n = 0;
  int both_n = 0;

  a_conditioner #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_raw     (a_raw),
    .clr_cnt   (clr_cnt),
    .a         (a),
    .a_rise    (a_rise),
    .a_fall    (a_fall),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle; tallies pulses seen after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (a_rise) rise_n++;
    if (a_fall) fall_n++;
    if (a_rise && a_fall) both_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_raw = 1'b0;
    clr_cnt = 1'b0;
    ticks(2);
    reset = 1'b0;
    rise_n = 0;
    fall_n = 0;
  endtask

  // Two-cycle high pulse from LOW: aborts at E3, then settles low.
  task automatic short_pulse();
    a_raw = 1'b1;
    ticks(2);
    a_raw = 1'b0;
    ticks(6);
  endtask

  initial begin
    // Reset held with a_raw high
    reset = 1'b1;
    a_raw = 1'b1;
    ticks(3);
    check("rst_a", a, 0);
    check("rst_busy", busy, 0);
    check("rst_glitch", glitch_cnt, 0);
    check("rst_rise", a_rise, 0);
    check("rst_fall", a_fall, 0);
    reset = 1'b0;
    rise_n = 0;
    ticks(5);                       // E0..E4
    check("post_rst_a_e4", a, 0);
    tick();                         // E5
    check("post_rst_a_e5", a, 1);
    check("post_rst_rise_e5", a_rise, 1);
    tick();
    check("post_rst_rise_e6", a_rise, 0);
    check("post_rst_rise_n", rise_n, 1);

    // Clean rise and fall
    do_reset();
    a_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) check("clean_a_before_rise", a, 0);
      if (i == 6) check("clean_rise_pulse", a_rise, 1);
    end
    check("clean_a_high", a, 1);
    a_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) check("clean_a_before_fall", a, 1);
      if (i == 6) check("clean_fall_pulse", a_fall, 1);
    end
    check("clean_a_low", a, 0);
    check("clean_rise_n", rise_n, 1);
    check("clean_fall_n", fall_n, 1);
    check("clean_glitch", glitch_cnt, 0);

    // Threshold: 4 cycles rejected, 5 cycles accepted
    do_reset();
    a_raw = 1'b1;
    ticks(4);
    a_raw = 1'b0;
    ticks(10);
    check("thr4_a", a, 0);
    check("thr4_rise_n", rise_n, 0);
    check("thr4_glitch", glitch_cnt, 1);
    a_raw = 1'b1;
    ticks(5);
    a_raw = 1'b0;
    ticks(20);
    check("thr5_rise_n", rise_n, 1);
    check("thr5_fall_n", fall_n, 1);
    check("thr5_a", a, 0);
    check("thr5_glitch", glitch_cnt, 1);

    // Glitch while HIGH
    do_reset();
    a_raw = 1'b1;
    ticks(10);
    check("hi_settled", a, 1);
    rise_n = 0;
    a_raw = 1'b0;
    ticks(2);                       // E0, E1: enters CHK_LO at E1
    check("hi_busy", busy, 1);
    check("hi_a_during", a, 1);
    a_raw = 1'b1;
    ticks(10);
    check("hi_a_after", a, 1);
    check("hi_glitch", glitch_cnt, 1);
    check("hi_fall_n", fall_n, 0);
    check("hi_busy_after", busy, 0);

    // Saturation and clear
    do_reset();
    for (int p = 0; p < 5; p++) short_pulse();
    check("sat_glitch", glitch_cnt, 3);
    check("sat_a", a, 0);
    check("sat_rise_n", rise_n, 0);
    a_raw = 1'b1;
    ticks(2);                       // E0, E1
    a_raw = 1'b0;
    tick();                         // E2: still checking, cnt=2
    check("clr_busy_pre", busy, 1);
    clr_cnt = 1'b1;
    tick();                         // E3: abort and clear together
    clr_cnt = 1'b0;
    check("clr_glitch", glitch_cnt, 0);
    check("clr_busy_post", busy, 0);
    ticks(4);
    check("clr_glitch_hold", glitch_cnt, 0);

    // Reset mid-check
    do_reset();
    short_pulse();
    check("mid_glitch_pre", glitch_cnt, 1);
    a_raw = 1'b1;
    ticks(4);                       // E3: CHK_HI with cnt=3
    check("mid_busy_pre", busy, 1);
    reset = 1'b1;
    a_raw = 1'b0;
    tick();
    reset = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_a", a, 0);
    check("mid_rise", a_rise, 0);
    check("mid_glitch", glitch_cnt, 0);
    ticks(8);
    check("mid_rise_n", rise_n, 0);
    check("mid_a_late", a, 0);
    check("mid_glitch_late", glitch_cnt, 0);

    // Toggle every cycle: each abort counts once, a never moves
    do_reset();
    a_raw = 1'b1; tick();
    a_raw = 1'b0; tick();
    a_raw = 1'b1; tick();
    a_raw = 1'b0; tick();
    ticks(6);
    check("tog_a", a, 0);
    check("tog_glitch", glitch_cnt, 2);
    check("tog_rise_n", rise_n, 0);

    check("pulses_exclusive", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a_conditioner.md
# a_conditioner

Input conditioning stage directly upstream of the `FSM` block. It takes the raw, asynchronous `a` input from the board. It synchronises that input to `clk`, debounces it with a four-state check machine, and drives the clean level `a` that the `FSM` block's `a` port consumes. It also produces one-cycle edge pulses and a saturating count of rejected glitches for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count; legal range ≥ 2.
- `STABLE_CYCLES`, default 4: extra consecutive synchronised samples needed to accept a level change; legal range ≥ 1.
- `CNT_W`, default 8: width of `glitch_cnt`.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high; sampled on `clk` rising edge.
- `a_raw`  in  1: raw asynchronous input.
- `clr_cnt`  in  1: synchronous clear of `glitch_cnt`.
- `a`  out  1: debounced level; connects to the `FSM` block's `a` input.
- `a_rise`  out  1: one-cycle pulse in the first cycle `a` reads 1.
- `a_fall`  out  1: one-cycle pulse in the first cycle `a` reads 0.
- `busy`  out  1: high while the state is CHK_HI or CHK_LO.
- `glitch_cnt`  out  `CNT_W`: saturating count of aborted checks.

## Operation
- Synchroniser:
  - `SYNC_STAGES`-deep shift chain clocked by `clk`.
  - `s` is the last stage.
  - Chain clears to 0 on reset.
- State machine has four states: LOW, CHK_HI, HIGH, CHK_LO.
- Check counter `cnt` is ceil(log2(STABLE_CYCLES+1)) bits wide.
- LOW:
  - `s`=1 → CHK_HI with `cnt`=1.
  - Otherwise stay in LOW.
- CHK_HI:
  - `s`=0 → LOW and glitch increment.
  - `s`=1 with `cnt`==`STABLE_CYCLES` → HIGH.
  - Otherwise `cnt`+1.
- HIGH:
  - `s`=0 → CHK_LO with `cnt`=1.
- CHK_LO is the mirror of CHK_HI:
  - `s`=1 → HIGH and glitch increment.
  - `s`=0 with `cnt`==`STABLE_CYCLES` → LOW.
  - Otherwise `cnt`+1.
- `a` = 1 in HIGH and CHK_LO; `a` = 0 in LOW and CHK_HI. `a` is registered, with no combinational path from `a_raw`.
- `a_rise` is 1 in the single cycle after the CHK_HI→HIGH edge; `a_fall` is 1 in the single cycle after the CHK_LO→LOW edge. The two pulses are never high together.
- `glitch_cnt`:
  - Increments by 1 on each aborted check.
  - Holds at all-ones and never wraps.
  - `clr_cnt` has priority over a simultaneous increment; the result is 0.
- Reset values:
  - State LOW, `cnt` 0.
  - `a`, `a_rise`, `a_fall`, `busy` all 0.
  - `glitch_cnt` 0.
  - Synchroniser 0.

## Timing
- Let E0 be the first edge that samples `a_raw`=1 into stage 1, with `a_raw` held steady.
- `s` is seen as 1 by the FSM from edge E(`SYNC_STAGES`−1).
- The state enters CHK_HI at that edge.
- The state enters HIGH at edge E(`SYNC_STAGES`−1+`STABLE_CYCLES`).
- `a` and `a_rise` are high after that edge. Defaults: `a` rises after E5, a latency of 5 edges.
- Acceptance needs `s` high on `STABLE_CYCLES`+1 consecutive edges (5 at defaults). A `a_raw` pulse spanning ≤ `STABLE_CYCLES` sampling edges is rejected and counted.
- Falling transitions have symmetric latency.
- Reset asserted mid-check:
  - Next state is LOW with `a`=0.
  - No `a_rise` or `a_fall` pulse.
  - `glitch_cnt` is cleared, not incremented.
- The first edge after reset deassertion behaves as an ordinary sample.
- A level toggling every cycle never changes `a`. Each abort in such a sequence counts once.

## Test plan
- **Reset:**
  - Stimulus: `a_raw`=1 and `reset`=1 for 3 cycles.
  - Response: `a`=0, `busy`=0, `glitch_cnt`=0, no pulses.
  - After `reset` falls: `a_rise` is a single pulse and `a`=1 after the 5th edge following the first post-reset sample.
- **Clean rise and fall (defaults):**
  - Stimulus: `a_raw` high for 10 cycles, then low for 10 cycles.
  - Response: exactly one `a_rise` and one `a_fall`, each 5 edges after the input change; `glitch_cnt`=0.
- **Threshold:**
  - Stimulus: `a_raw` high for exactly 4 cycles, then low → `a` stays 0, no `a_rise`, `glitch_cnt`=1.
  - Stimulus: `a_raw` high for exactly 5 cycles → `a` rises and then falls; `glitch_cnt` unchanged.
- **Glitch while HIGH:**
  - Stimulus: `a` settled at 1; `a_raw` low for 2 cycles.
  - Response: `a` stays 1, `busy` high during the check, `glitch_cnt` increments by 1, no `a_fall`.
- **Saturation and clear (`CNT_W`=2):**
  - Stimulus: 5 rejected 2-cycle pulses → `glitch_cnt`=3, held.
  - Stimulus: `clr_cnt` asserted in the same cycle as a 6th abort → `glitch_cnt`=0.
- **Reset mid-check:**
  - Stimulus: assert `reset` for 1 cycle while in CHK_HI with `cnt`=3.
  - Response: next cycle LOW, `a`=0, `busy`=0, no `a_rise`, `glitch_cnt`=0.
